pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_stall_cnt.sv | 21 ++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encodings and the canonical NOP.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } pc_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/pipe_stall_cnt.sv
// Loadable down-counter for multi-cycle stalls; last flags the final stall cycle.
module pipe_stall_cnt #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MC_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic                last
);
  logic [MC_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt <= '0;
    else if (load)                      cnt <= load_val;
    else if (dec && cnt != '0)          cnt <= cnt - MC_CNT_W'(1);
  end

  assign last = (cnt == MC_CNT_W'(1));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: redirects on jumps, stalls for multi-cycle EX ops,
// and halts on ebreak until resumed.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_en_i,
  input  logic [31:0]         jump_addr_i,
  input  logic                mc_req_i,
  input  logic [MC_CNT_W-1:0] mc_lat_i,
  input  logic                ebreak_i,
  input  logic                resume_i,
  output logic                hold_pc_o,
  output logic                hold_if_id_o,
  output logic                hold_id_ex_o,
  output logic                flush_if_id_o,
  output logic                flush_id_ex_o,
  output logic                pc_load_o,
  output logic [31:0]         pc_load_addr_o,
  output logic                mc_last_o,
  output logic                halt_o,
  output logic [1:0]          state_o
);
  pc_state_e state;
  logic      cnt_last;
  logic      mc_long, mc_one;

  assign mc_long = mc_req_i && (mc_lat_i > MC_CNT_W'(1));
  assign mc_one  = mc_req_i && (mc_lat_i == MC_CNT_W'(1));

  pipe_stall_cnt #(.MC_CNT_W(MC_CNT_W)) u_stall_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == RUN && !ebreak_i && !jump_en_i && mc_long),
    .load_val (mc_lat_i - MC_CNT_W'(1)),
    .dec      (state == MC_WAIT),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else begin
      case (state)
        RUN: begin
          if (ebreak_i)       state <= HALT;
          else if (jump_en_i) state <= REDIRECT;
          else if (mc_long)   state <= MC_WAIT;
        end
        MC_WAIT:  if (cnt_last) state <= RUN;
        REDIRECT: state <= RUN;
        HALT:     if (resume_i) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Outputs decode the current state and EX events in the same cycle; rst gates all to 0.
  always_comb begin
    hold_pc_o      = 1'b0;
    hold_if_id_o   = 1'b0;
    hold_id_ex_o   = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    pc_load_o      = 1'b0;
    pc_load_addr_o = '0;
    mc_last_o      = 1'b0;
    halt_o         = 1'b0;
    state_o        = state;
    case (state)
      RUN: begin
        if (ebreak_i) begin
          hold_pc_o     = 1'b1;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (jump_en_i) begin
          pc_load_o      = 1'b1;
          pc_load_addr_o = jump_addr_i;
          flush_if_id_o  = 1'b1;
          flush_id_ex_o  = 1'b1;
        end else if (mc_long || mc_one) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          mc_last_o    = mc_one;
        end
      end
      MC_WAIT: begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
        mc_last_o    = cnt_last;
      end
      REDIRECT: flush_if_id_o = 1'b1;
      HALT: begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
        halt_o       = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      hold_pc_o      = 1'b0;
      hold_if_id_o   = 1'b0;
      hold_id_ex_o   = 1'b0;
      flush_if_id_o  = 1'b0;
      flush_id_ex_o  = 1'b0;
      pc_load_o      = 1'b0;
      pc_load_addr_o = '0;
      mc_last_o      = 1'b0;
      halt_o         = 1'b0;
      state_o        = 2'd0;
    end
  end
endmodule
